// File: rtl/bf_fetch_unit.sv
// rtl/bf_fetch_unit.sv - Brainfuck instruction fetch and bracket-resolving loop control
// Holds a downloaded 3-bit opcode program and issues it to execute over a valid/ready handshake.
module bf_fetch_unit #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_valid,
  input  logic [2:0]        i_load_instr,
  output logic              o_load_ready,
  input  logic              i_start,
  input  logic              i_clear,
  output logic              o_instr_valid,
  output logic [2:0]        o_instr,
  input  logic              i_instr_ready,
  input  logic              i_cell_zero,
  output logic [ADDR_W:0]   o_pc,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_LOAD, S_RUN, S_SKIP_F, S_SKIP_B, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [2:0]      OP_OPEN  = 3'd6;
  localparam logic [2:0]      OP_CLOSE = 3'd7;

  state_t          r_state;
  logic [ADDR_W:0] r_pc;
  logic [ADDR_W:0] r_prog_len;
  logic [ADDR_W:0] r_depth;
  logic [2:0]      r_mem [PROG_DEPTH];

  state_t          w_state_nxt;
  logic [ADDR_W:0] w_pc_nxt;
  logic [ADDR_W:0] w_len_nxt;
  logic [ADDR_W:0] w_depth_nxt;
  logic            w_mem_we;
  logic [ADDR_W:0] w_pc_inc;
  logic [ADDR_W:0] w_pc_dec;
  logic            w_at_end;
  logic            w_pc_zero;
  logic            w_depth_one;

  assign w_pc_inc    = r_pc + LP_ONE;
  assign w_pc_dec    = r_pc - LP_ONE;
  assign w_at_end    = (r_pc == r_prog_len);
  assign w_pc_zero   = (r_pc == '0);
  assign w_depth_one = (r_depth == LP_ONE);

  // pc can equal PROG_DEPTH; the wrapped read is never consumed in that case.
  assign o_instr       = r_mem[r_pc[ADDR_W-1:0]];
  assign o_instr_valid = (r_state == S_RUN) && (r_pc < r_prog_len);
  assign o_load_ready  = (r_state == S_LOAD) && (r_prog_len < LP_DEPTH);
  assign o_done        = (r_state == S_DONE);
  assign o_error       = (r_state == S_ERR);
  assign o_pc          = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_prog_len;
    w_depth_nxt = r_depth;
    w_mem_we    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (i_load_valid && o_load_ready) begin
          w_mem_we  = 1'b1;
          w_len_nxt = r_prog_len + LP_ONE;
        end
        if (i_start) begin
          w_pc_nxt    = '0;
          w_state_nxt = (w_len_nxt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_at_end) begin
          w_state_nxt = S_DONE;
        end else if (i_instr_ready) begin
          if (o_instr == OP_OPEN && i_cell_zero) begin
            w_pc_nxt    = w_pc_inc;
            w_depth_nxt = LP_ONE;
            w_state_nxt = S_SKIP_F;
          end else if (o_instr == OP_CLOSE && !i_cell_zero) begin
            w_depth_nxt = LP_ONE;
            if (w_pc_zero) begin
              w_state_nxt = S_ERR;
            end else begin
              w_pc_nxt    = w_pc_dec;
              w_state_nxt = S_SKIP_B;
            end
          end else begin
            w_pc_nxt = w_pc_inc;
          end
          // Finishing on the last slot goes straight to DONE so done follows the last transfer.
          if (w_state_nxt == S_RUN && w_pc_nxt == r_prog_len) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SKIP_F: begin
        if (w_at_end) begin
          w_state_nxt = S_ERR;
        end else begin
          w_pc_nxt = w_pc_inc;
          if (o_instr == OP_OPEN) begin
            w_depth_nxt = r_depth + LP_ONE;
          end else if (o_instr == OP_CLOSE) begin
            if (w_depth_one) w_state_nxt = S_RUN;
            else             w_depth_nxt = r_depth - LP_ONE;
          end
        end
      end
      S_SKIP_B: begin
        if (o_instr == OP_OPEN && w_depth_one) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_RUN;
        end else begin
          if (o_instr == OP_CLOSE)     w_depth_nxt = r_depth + LP_ONE;
          else if (o_instr == OP_OPEN) w_depth_nxt = r_depth - LP_ONE;
          if (w_pc_zero) w_state_nxt = S_ERR;
          else           w_pc_nxt    = w_pc_dec;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
    if (i_clear) begin
      w_state_nxt = S_LOAD;
      w_pc_nxt    = '0;
      w_len_nxt   = '0;
      w_depth_nxt = '0;
      w_mem_we    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_LOAD;
      r_pc       <= '0;
      r_prog_len <= '0;
      r_depth    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_prog_len <= w_len_nxt;
      r_depth    <= w_depth_nxt;
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_prog_len[ADDR_W-1:0]] <= i_load_instr;
  end

endmodule

// File: tb/tb_bf_fetch_unit.sv
// tb/tb_bf_fetch_unit.sv - self-checking bench for bf_fetch_unit
// Program vectors run through a transfer scoreboard; hand sequences cover cycle-exact corners.
module tb_bf_fetch_unit;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_load_valid = 1'b0;
  logic [2:0] i_load_instr = 3'd0;
  logic       o_load_ready;
  logic       i_start = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_instr_valid;
  logic [2:0] o_instr;
  logic       i_instr_ready = 1'b0;
  logic       i_cell_zero = 1'b0;
  logic [5:0] o_pc;
  logic       o_done;
  logic       o_error;

  int n_checks = 0;
  int n_err    = 0;

  bf_fetch_unit #(.PROG_DEPTH(32), .ADDR_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load_valid(i_load_valid), .i_load_instr(i_load_instr), .o_load_ready(o_load_ready),
    .i_start(i_start), .i_clear(i_clear),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .i_instr_ready(i_instr_ready),
    .i_cell_zero(i_cell_zero), .o_pc(o_pc), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string name;
    string prog;
    string cz;
    string pcs;
    bit    err;
  } vec_t;

  typedef struct packed {
    logic [2:0] op;
    logic [5:0] pc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  function automatic logic [2:0] enc(input byte c);
    case (c)
      ">": return 3'd0;
      "<": return 3'd1;
      "+": return 3'd2;
      "-": return 3'd3;
      ".": return 3'd4;
      ",": return 3'd5;
      "[": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_load_valid = 1'b0; i_start = 1'b0; i_clear = 1'b0;
    i_instr_ready = 1'b0; i_cell_zero = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic load_str(input string p);
    for (int k = 0; k < p.len(); k++) begin
      i_load_valid = 1'b1;
      i_load_instr = enc(p[k]);
      @(negedge i_clk);
    end
    i_load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   idx;
    int   p;
    do_reset();
    load_str(v.prog);
    for (int k = 0; k < v.pcs.len(); k++) begin
      p    = int'(v.pcs[k]) - 48;
      e.pc = 6'(p);
      e.op = enc(v.prog[p]);
      sb.push_back(e);
    end
    pulse_start();
    i_instr_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (o_done || o_error) break;
      i_cell_zero = (idx < v.cz.len()) ? (v.cz[idx] == "1") : 1'b0;
      if (o_instr_valid) begin
        if (sb.size() == 0) begin
          chk({v.name, " extra transfer pc"}, 32'(o_pc), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk({v.name, " op"}, 32'(o_instr), 32'(e.op));
          chk({v.name, " pc"}, 32'(o_pc), 32'(e.pc));
        end
        idx++;
      end
      @(negedge i_clk);
    end
    chk({v.name, " done"}, 32'(o_done), 32'(!v.err));
    chk({v.name, " error"}, 32'(o_error), 32'(v.err));
    chk({v.name, " missing transfers"}, 32'(sb.size()), 32'd0);
    sb.delete();
    i_instr_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_xfer;
    int n_bad;
    int last_pc;

    vecs[0] = '{"plus_plus_out", "++.",    "",       "012",    1'b0};
    vecs[1] = '{"fwd_skip",      "[+]-",   "1",      "03",     1'b0};
    vecs[2] = '{"loop_back",     "[+]-",   "000010", "012123", 1'b0};
    vecs[3] = '{"unmatched_fwd", "[++",    "1",      "0",      1'b1};
    vecs[4] = '{"close_at_zero", "]",      "0",      "0",      1'b1};
    vecs[5] = '{"nested_fwd",    "[[+]]-", "1",      "05",     1'b0};
    vecs[6] = '{"all_plain_ops", "><+-.,", "",       "012345", 1'b0};
    vecs[7] = '{"empty_loop",    "[]",     "001",    "011",    1'b0};
    vecs[8] = '{"unmatched_bwd", "+]",     "00",     "01",     1'b1};

    @(negedge i_clk);
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset values, basic run with backpressure, rerun from DONE, clear mid-run.
    do_reset();
    chk("rst load_ready", 32'(o_load_ready), 32'd1);
    chk("rst instr_valid", 32'(o_instr_valid), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst error", 32'(o_error), 32'd0);
    chk("rst pc", 32'(o_pc), 32'd0);
    load_str("++.");
    pulse_start();
    i_instr_ready = 1'b1;
    chk("basic c0 valid", 32'(o_instr_valid), 32'd1);
    chk("basic c0 pc", 32'(o_pc), 32'd0);
    chk("basic c0 op", 32'(o_instr), 32'd2);
    @(negedge i_clk);
    chk("basic c1 pc", 32'(o_pc), 32'd1);
    i_instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("stall valid", 32'(o_instr_valid), 32'd1);
      chk("stall pc", 32'(o_pc), 32'd1);
      chk("stall op", 32'(o_instr), 32'd2);
    end
    i_instr_ready = 1'b1;
    @(negedge i_clk);
    chk("basic c2 pc", 32'(o_pc), 32'd2);
    chk("basic c2 op", 32'(o_instr), 32'd4);
    @(negedge i_clk);
    chk("basic done", 32'(o_done), 32'd1);
    chk("basic done valid", 32'(o_instr_valid), 32'd0);
    pulse_start();
    chk("rerun done", 32'(o_done), 32'd0);
    chk("rerun pc", 32'(o_pc), 32'd0);
    chk("rerun op", 32'(o_instr), 32'd2);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    i_instr_ready = 1'b0;
    chk("clear run load_ready", 32'(o_load_ready), 32'd1);
    chk("clear run valid", 32'(o_instr_valid), 32'd0);
    chk("clear run pc", 32'(o_pc), 32'd0);
    pulse_start();
    chk("clear run empty prog done", 32'(o_done), 32'd1);

    // Forward skip cycle-exact, then reset in the middle of a skip.
    do_reset();
    load_str("[+]-");
    pulse_start();
    i_instr_ready = 1'b1;
    i_cell_zero = 1'b1;
    chk("fskip op", 32'(o_instr), 32'd6);
    @(negedge i_clk);
    chk("fskip gap1 valid", 32'(o_instr_valid), 32'd0);
    @(negedge i_clk);
    chk("fskip gap2 valid", 32'(o_instr_valid), 32'd0);
    @(negedge i_clk);
    chk("fskip resume valid", 32'(o_instr_valid), 32'd1);
    chk("fskip resume pc", 32'(o_pc), 32'd3);
    chk("fskip resume op", 32'(o_instr), 32'd3);
    @(negedge i_clk);
    chk("fskip done", 32'(o_done), 32'd1);
    pulse_start();
    @(negedge i_clk);
    chk("pre rst in skip pc", 32'(o_pc), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst skip pc", 32'(o_pc), 32'd0);
    chk("rst skip valid", 32'(o_instr_valid), 32'd0);
    chk("rst skip load_ready", 32'(o_load_ready), 32'd1);
    chk("rst skip error", 32'(o_error), 32'd0);
    pulse_start();
    chk("rst skip empty prog done", 32'(o_done), 32'd1);

    // Leaving ERR via clear.
    run_vec(vecs[3]);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    chk("clear err fwd load_ready", 32'(o_load_ready), 32'd1);
    chk("clear err fwd error", 32'(o_error), 32'd0);
    run_vec(vecs[4]);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    chk("clear err bwd load_ready", 32'(o_load_ready), 32'd1);
    chk("clear err bwd error", 32'(o_error), 32'd0);

    // Full memory: 33rd offer is a different opcode and must not land anywhere.
    do_reset();
    for (int k = 0; k < 33; k++) begin
      if (k == 31) chk("full before 32nd ready", 32'(o_load_ready), 32'd1);
      if (k == 32) chk("full after 32nd ready", 32'(o_load_ready), 32'd0);
      i_load_valid = 1'b1;
      i_load_instr = (k == 32) ? 3'd0 : 3'd2;
      @(negedge i_clk);
    end
    i_load_valid = 1'b0;
    pulse_start();
    i_instr_ready = 1'b1;
    n_xfer = 0; n_bad = 0; last_pc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (o_done) break;
      if (o_instr_valid) begin
        n_xfer++;
        if (o_instr != 3'd2) n_bad++;
        last_pc = int'(o_pc);
      end
      @(negedge i_clk);
    end
    chk("full transfers", 32'(n_xfer), 32'd32);
    chk("full bad ops", 32'(n_bad), 32'd0);
    chk("full last pc", 32'(last_pc), 32'd31);
    chk("full done", 32'(o_done), 32'd1);
    chk("full done pc", 32'(o_pc), 32'd32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
